mc6820_pia: RTL and testbench

Synchronous model of the MC6820 Peripheral Interface Adapter (PIA): two 8-bit bidirectional peripheral ports, A and B. Each port has a data-direction register, an output register and a control register, plus two handshake/interrupt lines (CA1/CA2, CB1/CB2). The block sits on the CPU data bus as a 4-register device and drives active-low interrupt requests to the CPU. Everything runs in the single bus clock domain; there are no tristate buses (split in/out ports).

---
 rtl/mc6820_pia.sv | 141 ++++++++++++++
 tb/tb_mc6820_pia.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc6820_pia.sv
// MC6820 peripheral interface adapter: two 8-bit ports with direction, output and
// control registers, Cx1/Cx2 edge flags, Cx2 handshake/pulse outputs and active-low IRQs.
module mc6820_pia (
  input  logic       enable,
  input  logic       reset_n,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic [7:0] PAI,
  output logic [7:0] PAO,
  input  logic [7:0] PBI,
  output logic [7:0] PBO,
  input  logic       CA1,
  input  logic       CB1,
  input  logic       CA2I,
  output logic       CA2O,
  input  logic       CB2I,
  output logic       CB2O,
  input  logic [2:0] CS,
  input  logic [1:0] RS,
  input  logic       rw,
  output logic       irqA,
  output logic       irqB
);

  localparam int unsigned DW = 8;
  localparam logic [2:0] CS_SEL = 3'b011;

  logic [DW-1:0] ddra, ora, cra;
  logic [DW-1:0] ddrb, orb, crb;
  logic ca1_s1, ca1_s2, ca2_s1, ca2_s2;
  logic cb1_s1, cb1_s2, cb2_s1, cb2_s2;
  logic ca2_hs, cb2_hs;
  logic ca2_hs_nxt, cb2_hs_nxt;

  logic sel, rd, wr;
  logic porta_acc, portb_acc;
  logic clr_a, clr_b, trig_a, trig_b;
  logic ca1_act, ca2_act, cb1_act, cb2_act;
  logic [DW-1:0] portb_val;

  assign sel       = (CS == CS_SEL);
  assign rd        = sel & rw;
  assign wr        = sel & ~rw;
  assign porta_acc = (RS == 2'b00) & cra[2];
  assign portb_acc = (RS == 2'b10) & crb[2];
  assign clr_a     = rd & porta_acc;
  assign clr_b     = rd & portb_acc;
  assign trig_a    = clr_a;
  assign trig_b    = wr & portb_acc;

  // Sampled-edge detection: s1 is the current sample, s2 the previous one
  assign ca1_act = cra[1] ? (ca1_s1 & ~ca1_s2) : (~ca1_s1 & ca1_s2);
  assign ca2_act = cra[4] ? (ca2_s1 & ~ca2_s2) : (~ca2_s1 & ca2_s2);
  assign cb1_act = crb[1] ? (cb1_s1 & ~cb1_s2) : (~cb1_s1 & cb1_s2);
  assign cb2_act = crb[4] ? (cb2_s1 & ~cb2_s2) : (~cb2_s1 & cb2_s2);

  assign portb_val = (orb & ddrb) | (PBI & ~ddrb);

  assign PAO  = ora & ddra;
  assign PBO  = orb & ddrb;
  assign CA2O = ~cra[5] | (cra[4] ? cra[3] : ca2_hs);
  assign CB2O = ~crb[5] | (crb[4] ? crb[3] : cb2_hs);
  assign irqA = ~((cra[7] & cra[0]) | (cra[6] & cra[3] & ~cra[5]));
  assign irqB = ~((crb[7] & crb[0]) | (crb[6] & crb[3] & ~crb[5]));

  // Handshake/pulse state; a Cx1 edge beats a same-cycle trigger in handshake mode
  always_comb begin
    ca2_hs_nxt = 1'b1;
    cb2_hs_nxt = 1'b1;
    if (cra[5] & ~cra[4]) begin
      if (cra[3])       ca2_hs_nxt = ~trig_a;
      else if (ca1_act) ca2_hs_nxt = 1'b1;
      else if (trig_a)  ca2_hs_nxt = 1'b0;
      else              ca2_hs_nxt = ca2_hs;
    end
    if (crb[5] & ~crb[4]) begin
      if (crb[3])       cb2_hs_nxt = ~trig_b;
      else if (cb1_act) cb2_hs_nxt = 1'b1;
      else if (trig_b)  cb2_hs_nxt = 1'b0;
      else              cb2_hs_nxt = cb2_hs;
    end
  end

  always_comb begin
    DO = '0;
    if (rd) begin
      case (RS)
        2'b00:   DO = cra[2] ? PAI : ddra;
        2'b01:   DO = cra;
        2'b10:   DO = crb[2] ? portb_val : ddrb;
        default: DO = crb;
      endcase
    end
  end

  always_ff @(posedge enable) begin
    if (reset_n) begin
      ddra   <= '0;
      ora    <= '0;
      cra    <= '0;
      ddrb   <= '0;
      orb    <= '0;
      crb    <= '0;
      ca2_hs <= 1'b1;
      cb2_hs <= 1'b1;
      ca1_s1 <= CA1;
      ca1_s2 <= CA1;
      ca2_s1 <= CA2I;
      ca2_s2 <= CA2I;
      cb1_s1 <= CB1;
      cb1_s2 <= CB1;
      cb2_s1 <= CB2I;
      cb2_s2 <= CB2I;
    end else begin
      ca1_s1 <= CA1;
      ca1_s2 <= ca1_s1;
      ca2_s1 <= CA2I;
      ca2_s2 <= ca2_s1;
      cb1_s1 <= CB1;
      cb1_s2 <= cb1_s1;
      cb2_s1 <= CB2I;
      cb2_s2 <= cb2_s1;
      ca2_hs <= ca2_hs_nxt;
      cb2_hs <= cb2_hs_nxt;
      if (wr) begin
        case (RS)
          2'b00:   if (cra[2]) ora <= DI; else ddra <= DI;
          2'b01:   cra[5:0] <= DI[5:0];
          2'b10:   if (crb[2]) orb <= DI; else ddrb <= DI;
          default: crb[5:0] <= DI[5:0];
        endcase
      end
      // Flags: set wins over a same-cycle clearing read
      cra[7] <= ca1_act | (cra[7] & ~clr_a);
      cra[6] <= (ca2_act & ~cra[5]) | (cra[6] & ~clr_a);
      crb[7] <= cb1_act | (crb[7] & ~clr_b);
      crb[6] <= (cb2_act & ~crb[5]) | (crb[6] & ~clr_b);
    end
  end

endmodule

// File: tb/tb_mc6820_pia.sv
// Scoreboard bench for mc6820_pia: expectations queued with stimulus, popped at sampling.
module tb_mc6820_pia;

  logic       clk;
  logic       reset_n;
  logic [7:0] DI, DO, PAI, PAO, PBI, PBO;
  logic       CA1, CB1, CA2I, CA2O, CB2I, CB2O;
  logic [2:0] CS;
  logic [1:0] RS;
  logic       rw;
  logic       irqA, irqB;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp;

  mc6820_pia dut (
    .enable(clk), .reset_n(reset_n), .DI(DI), .DO(DO),
    .PAI(PAI), .PAO(PAO), .PBI(PBI), .PBO(PBO),
    .CA1(CA1), .CB1(CB1), .CA2I(CA2I), .CA2O(CA2O),
    .CB2I(CB2I), .CB2O(CB2O), .CS(CS), .RS(RS), .rw(rw),
    .irqA(irqA), .irqB(irqB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] rs, input logic [7:0] d);
    CS = 3'b011; rw = 1'b0; RS = rs; DI = d;
    cyc();
    CS = 3'b000; rw = 1'b1; DI = 8'h00;
  endtask

  // Drive a read, let DO settle before the edge; caller samples DO then calls read_end
  task automatic read_begin(input logic [1:0] rs);
    CS = 3'b011; rw = 1'b1; RS = rs;
    #1;
  endtask

  task automatic read_end();
    cyc();
    CS = 3'b000;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    cyc(); cyc();
    reset_n = 1'b0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h01);
    read_begin(2'b01);
    exp = exp_q.pop_front(); checks++;
    if (DO !== exp) begin errors++; $display("FAIL reset_cra: got %h want %h", DO, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, irqA} !== exp) begin errors++; $display("FAIL reset_irqa: got %b want %b", irqA, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, CA2O} !== exp) begin errors++; $display("FAIL reset_ca2o: got %b want %b", CA2O, exp[0]); end
    read_end();
  endtask

  task automatic test_ca1_flag();
    bus_write(2'b01, 8'h01);
    exp_q.push_back(8'h01);
    read_begin(2'b01);
    exp = exp_q.pop_front(); checks++;
    if (DO !== exp) begin errors++; $display("FAIL cra_write: got %h want %h", DO, exp); end
    read_end();
    CA1 = 1'b0;
    cyc();
    exp_q.push_back(8'h01);
    read_begin(2'b01);
    exp = exp_q.pop_front(); checks++;
    if (DO !== exp) begin errors++; $display("FAIL ca1_latency: got %h want %h", DO, exp); end
    read_end();
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h00);
    read_begin(2'b01);
    exp = exp_q.pop_front(); checks++;
    if (DO !== exp) begin errors++; $display("FAIL ca1_flag: got %h want %h", DO, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, irqA} !== exp) begin errors++; $display("FAIL ca1_irqa: got %b want %b", irqA, exp[0]); end
    read_end();
    CA1 = 1'b1;
    cyc(); cyc();
    exp_q.push_back(8'h81);
    read_begin(2'b01);
    exp = exp_q.pop_front(); checks++;
    if (DO !== exp) begin errors++; $display("FAIL ca1_rise_ignored: got %h want %h", DO, exp); end
    read_end();
  endtask

  task automatic test_flag_clear();
    bus_write(2'b01, 8'h05);
    exp_q.push_back(8'h85);
    read_begin(2'b01);
    exp = exp_q.pop_front(); checks++;
    if (DO !== exp) begin errors++; $display("FAIL flag_preserved: got %h want %h", DO, exp); end
    read_end();
    PAI = 8'hFF;
    exp_q.push_back(8'hFF);
    read_begin(2'b00);
    exp = exp_q.pop_front(); checks++;
    if (DO !== exp) begin errors++; $display("FAIL porta_read: got %h want %h", DO, exp); end
    read_end();
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h01);
    read_begin(2'b01);
    exp = exp_q.pop_front(); checks++;
    if (DO !== exp) begin errors++; $display("FAIL flag_cleared: got %h want %h", DO, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, irqA} !== exp) begin errors++; $display("FAIL irqa_cleared: got %b want %b", irqA, exp[0]); end
    read_end();
  endtask

  task automatic test_port_b();
    bus_write(2'b11, 8'h00);
    bus_write(2'b10, 8'h0F);
    bus_write(2'b11, 8'h04);
    bus_write(2'b10, 8'hA5);
    PBI = 8'h30;
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h35);
    #1;
    exp = exp_q.pop_front(); checks++;
    if (PBO !== exp) begin errors++; $display("FAIL pbo: got %h want %h", PBO, exp); end
    read_begin(2'b10);
    exp = exp_q.pop_front(); checks++;
    if (DO !== exp) begin errors++; $display("FAIL portb_read: got %h want %h", DO, exp); end
    read_end();
  endtask

  task automatic test_cx2_out();
    bus_write(2'b01, 8'h24);
    exp_q.push_back(8'h01);
    #1;
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, CA2O} !== exp) begin errors++; $display("FAIL ca2o_idle: got %b want %b", CA2O, exp[0]); end
    read_begin(2'b00);
    read_end();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, CA2O} !== exp) begin errors++; $display("FAIL ca2o_hs_low: got %b want %b", CA2O, exp[0]); end
    cyc(); cyc();
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, CA2O} !== exp) begin errors++; $display("FAIL ca2o_hs_hold: got %b want %b", CA2O, exp[0]); end
    CA1 = 1'b0;
    cyc();
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, CA2O} !== exp) begin errors++; $display("FAIL ca2o_hs_wait: got %b want %b", CA2O, exp[0]); end
    cyc();
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, CA2O} !== exp) begin errors++; $display("FAIL ca2o_hs_release: got %b want %b", CA2O, exp[0]); end
    bus_write(2'b11, 8'h2C);
    bus_write(2'b10, 8'h5A);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h01);
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, CB2O} !== exp) begin errors++; $display("FAIL cb2o_pulse_low: got %b want %b", CB2O, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (PBO !== exp) begin errors++; $display("FAIL pbo_after_pulse: got %h want %h", PBO, exp); end
    cyc();
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, CB2O} !== exp) begin errors++; $display("FAIL cb2o_pulse_end: got %b want %b", CB2O, exp[0]); end
  endtask

  task automatic test_ca2_in_and_reset();
    bus_write(2'b01, 8'h1C);
    read_begin(2'b00);
    read_end();
    CA2I = 1'b1;
    cyc(); cyc();
    exp_q.push_back(8'h5C);
    exp_q.push_back(8'h00);
    read_begin(2'b01);
    exp = exp_q.pop_front(); checks++;
    if (DO !== exp) begin errors++; $display("FAIL ca2_flag: got %h want %h", DO, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, irqA} !== exp) begin errors++; $display("FAIL ca2_irqa: got %b want %b", irqA, exp[0]); end
    read_end();
    // Reset with a simultaneous CRA write; reset must dominate
    reset_n = 1'b1;
    CS = 3'b011; rw = 1'b0; RS = 2'b01; DI = 8'hFF;
    cyc();
    CS = 3'b000; rw = 1'b1;
    reset_n = 1'b0;
    cyc(); cyc();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    read_begin(2'b01);
    exp = exp_q.pop_front(); checks++;
    if (DO !== exp) begin errors++; $display("FAIL reset_mid_cra: got %h want %h", DO, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, irqA} !== exp) begin errors++; $display("FAIL reset_mid_irqa: got %b want %b", irqA, exp[0]); end
    read_end();
    read_begin(2'b11);
    exp = exp_q.pop_front(); checks++;
    if (DO !== exp) begin errors++; $display("FAIL reset_mid_crb: got %h want %h", DO, exp); end
    read_end();
    exp = exp_q.pop_front(); checks++;
    if (PBO !== exp) begin errors++; $display("FAIL reset_mid_pbo: got %h want %h", PBO, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({7'b0, CB2O} !== exp) begin errors++; $display("FAIL reset_mid_cb2o: got %b want %b", CB2O, exp[0]); end
  endtask

  task automatic test_set_wins();
    bus_write(2'b01, 8'h05);
    CA1 = 1'b1;
    cyc();
    // Rising CA1 not active; make edge falling and clear on the same edge it lands
    CA1 = 1'b0;
    cyc();
    read_begin(2'b00);
    read_end();
    exp_q.push_back(8'h85);
    read_begin(2'b01);
    exp = exp_q.pop_front(); checks++;
    if (DO !== exp) begin errors++; $display("FAIL set_wins: got %h want %h", DO, exp); end
    read_end();
  endtask

  initial begin
    reset_n = 1'b0; DI = 8'h00; PAI = 8'h00; PBI = 8'h00;
    CA1 = 1'b1; CB1 = 1'b1; CA2I = 1'b0; CB2I = 1'b0;
    CS = 3'b000; RS = 2'b00; rw = 1'b1;
    test_reset();
    test_ca1_flag();
    test_flag_clear();
    test_port_b();
    test_cx2_out();
    test_ca2_in_and_reset();
    test_set_wins();
    if (exp_q.size() != 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
